mac_result_stage: RTL and testbench



---
 rtl/mac_result_stage_if.sv | 41 ++++
 rtl/mac_result_stage.sv | 82 ++++++++
 tb/tb_mac_result_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_result_stage_if.sv
// Signal bundle for the FMA result stage: upstream push side, writeback pop side,
// and the fflags CSR access port.
interface mac_result_stage_if #(
   parameter int PARM_EXP  = 8,
   parameter int PARM_MANT = 23,
   parameter int PARM_CNT  = 16
) ();
   logic                        Valid_i;
   logic                        Ready_o;
   logic                        Sign_result_i;
   logic [PARM_EXP-1:0]         Exp_result_i;
   logic [PARM_MANT-1:0]        Mant_result_i;
   logic                        Invalid_i;
   logic                        Overflow_i;
   logic                        Underflow_i;
   logic                        Inexact_i;
   logic                        Valid_o;
   logic                        Ready_i;
   logic [PARM_EXP+PARM_MANT:0] Result_o;
   logic [4:0]                  Fflags_o;
   logic                        Csr_wr_i;
   logic                        Csr_clr_i;
   logic [4:0]                  Csr_wdata_i;
   logic [4:0]                  Fflags_acc_o;
   logic [PARM_CNT-1:0]         Retired_cnt_o;

   // master drives results/CSR and the writeback ready; slave is the stage itself
   modport master (
      output Valid_i, Sign_result_i, Exp_result_i, Mant_result_i,
             Invalid_i, Overflow_i, Underflow_i, Inexact_i,
             Ready_i, Csr_wr_i, Csr_clr_i, Csr_wdata_i,
      input  Ready_o, Valid_o, Result_o, Fflags_o, Fflags_acc_o, Retired_cnt_o
   );

   modport slave (
      input  Valid_i, Sign_result_i, Exp_result_i, Mant_result_i,
             Invalid_i, Overflow_i, Underflow_i, Inexact_i,
             Ready_i, Csr_wr_i, Csr_clr_i, Csr_wdata_i,
      output Ready_o, Valid_o, Result_o, Fflags_o, Fflags_acc_o, Retired_cnt_o
   );
endinterface

// File: rtl/mac_result_stage.sv
// FMA output stage: packs rounded results into IEEE-754 words, buffers them in a
// 2-entry FIFO toward writeback, and keeps accrued fflags plus a retired-op count.
module mac_result_stage #(
   parameter int                          PARM_EXP  = 8,
   parameter int                          PARM_MANT = 23,
   parameter int                          PARM_CNT  = 16,
   parameter logic [PARM_EXP+PARM_MANT:0] PARM_NAN  = 32'h7FC0_0000
) (
   input logic               clk_i,
   input logic               rst_i,
   mac_result_stage_if.slave bus
);
   localparam int                  W       = PARM_EXP + PARM_MANT + 1;
   localparam logic [PARM_CNT-1:0] CNT_ONE = 1;

   typedef struct packed {
      logic [W-1:0] result;
      logic [4:0]   flags;
   } entry_t;

   entry_t              fifo_q [2];
   entry_t              push_entry;
   logic                wr_ptr_q;
   logic                rd_ptr_q;
   logic [1:0]          count_q;
   logic [4:0]          acc_q;
   logic [4:0]          acc_base;
   logic [PARM_CNT-1:0] cnt_q;
   logic                push;
   logic                pop;

   // Every output below is a function of registers only.
   assign bus.Ready_o       = (count_q != 2'd2);
   assign bus.Valid_o       = (count_q != 2'd0);
   assign bus.Result_o      = bus.Valid_o ? fifo_q[rd_ptr_q].result : '0;
   assign bus.Fflags_o      = bus.Valid_o ? fifo_q[rd_ptr_q].flags  : 5'd0;
   assign bus.Fflags_acc_o  = acc_q;
   assign bus.Retired_cnt_o = cnt_q;

   assign push = bus.Valid_i & bus.Ready_o;
   assign pop  = bus.Valid_o & bus.Ready_i;

   // Invalid ops yield the canonical NaN; DZ never arises here and overflow implies inexact.
   always_comb begin
      push_entry.result = bus.Invalid_i ? PARM_NAN
                                        : {bus.Sign_result_i, bus.Exp_result_i, bus.Mant_result_i};
      push_entry.flags  = {bus.Invalid_i, 1'b0, bus.Overflow_i, bus.Underflow_i,
                           bus.Inexact_i | bus.Overflow_i};
   end

   // CSR write beats clear; retiring flags are OR'd in afterwards so none are lost.
   always_comb begin
      acc_base = acc_q;
      if (bus.Csr_wr_i)       acc_base = bus.Csr_wdata_i;
      else if (bus.Csr_clr_i) acc_base = 5'd0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         acc_q    <= 5'd0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
            cnt_q    <= cnt_q + CNT_ONE;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
         acc_q <= acc_base | (pop ? fifo_q[rd_ptr_q].flags : 5'd0);
      end
   end
endmodule

// File: tb/tb_mac_result_stage.sv
// Randomized and directed checks of mac_result_stage against a queue-based model.
module tb_mac_result_stage;
   typedef struct packed {
      logic        v;
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
      logic        inv;
      logic        ovf;
      logic        unf;
      logic        inx;
   } req_t;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  flags;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   exp_t        mq[$];
   logic [4:0]  m_acc;
   logic [15:0] m_cnt;

   mac_result_stage_if bus ();

   mac_result_stage dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic req_t mk(input logic s, input logic [7:0] e, input logic [22:0] m,
                               input logic inv, input logic ovf, input logic unf, input logic inx);
      req_t r;
      r.v = 1'b1; r.s = s; r.e = e; r.m = m;
      r.inv = inv; r.ovf = ovf; r.unf = unf; r.inx = inx;
      return r;
   endfunction

   function automatic req_t idle();
      req_t r;
      r = '0;
      return r;
   endfunction

   // IEEE packing rules for the expected FIFO entry.
   function automatic exp_t expect_of(input req_t r);
      exp_t x;
      x.result = r.inv ? 32'h7FC0_0000 : {r.s, r.e, r.m};
      x.flags  = {r.inv, 1'b0, r.ovf, r.unf, (r.inx || r.ovf)};
      return x;
   endfunction

   // Drive one cycle of inputs and advance the model over the following rising edge.
   task automatic step(input req_t r, input logic rdy, input logic wr, input logic clr,
                       input logic [4:0] wd);
      bit         do_push;
      bit         do_pop;
      logic [4:0] nacc;
      bus.Valid_i       = r.v;
      bus.Sign_result_i = r.s;
      bus.Exp_result_i  = r.e;
      bus.Mant_result_i = r.m;
      bus.Invalid_i     = r.inv;
      bus.Overflow_i    = r.ovf;
      bus.Underflow_i   = r.unf;
      bus.Inexact_i     = r.inx;
      bus.Ready_i       = rdy;
      bus.Csr_wr_i      = wr;
      bus.Csr_clr_i     = clr;
      bus.Csr_wdata_i   = wd;
      do_push = r.v && (mq.size() < 2);
      do_pop  = rdy && (mq.size() > 0);
      nacc = wr ? wd : (clr ? 5'd0 : m_acc);
      if (do_pop) nacc = nacc | mq[0].flags;
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
         m_acc = 5'd0;
         m_cnt = 16'd0;
      end else begin
         if (do_pop) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (do_push) mq.push_back(expect_of(r));
         m_acc = nacc;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(idle(), 1'b0, 1'b0, 1'b0, 5'd0);
      rst = 1'b0;
      n_cmp++; if (bus.Valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.Valid_o); end
      n_cmp++; if (bus.Ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", bus.Ready_o); end
      n_cmp++; if (bus.Result_o !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h exp=0", bus.Result_o); end
      n_cmp++; if (bus.Fflags_o !== 5'd0) begin n_err++; $display("FAIL reset_fflags got=%b exp=0", bus.Fflags_o); end
      n_cmp++; if (bus.Fflags_acc_o !== 5'd0) begin n_err++; $display("FAIL reset_acc got=%b exp=0", bus.Fflags_acc_o); end
      n_cmp++; if (bus.Retired_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", bus.Retired_cnt_o); end
   endtask

   task automatic test_basic();
      step(mk(1'b0, 8'h7F, 23'd0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", bus.Valid_o); end
      n_cmp++; if (bus.Result_o !== 32'h3F80_0000) begin n_err++; $display("FAIL basic_result got=%h exp=3f800000", bus.Result_o); end
      n_cmp++; if (bus.Fflags_o !== 5'd0) begin n_err++; $display("FAIL basic_fflags got=%b exp=00000", bus.Fflags_o); end
      step(idle(), 1'b1, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Retired_cnt_o !== 16'd1) begin n_err++; $display("FAIL basic_cnt got=%0d exp=1", bus.Retired_cnt_o); end
      n_cmp++; if (bus.Valid_o !== 1'b0) begin n_err++; $display("FAIL basic_drain got=%b exp=0", bus.Valid_o); end
   endtask

   task automatic test_invalid();
      step(mk(1'b1, 8'hFF, 23'd1, 1, 0, 0, 0), 1'b0, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Result_o !== 32'h7FC0_0000) begin n_err++; $display("FAIL invalid_result got=%h exp=7fc00000", bus.Result_o); end
      n_cmp++; if (bus.Fflags_o !== 5'b10000) begin n_err++; $display("FAIL invalid_fflags got=%b exp=10000", bus.Fflags_o); end
      step(idle(), 1'b1, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Fflags_acc_o !== 5'b10000) begin n_err++; $display("FAIL invalid_acc got=%b exp=10000", bus.Fflags_acc_o); end
   endtask

   task automatic test_overflow();
      step(mk(1'b0, 8'hFF, 23'd0, 0, 1, 0, 0), 1'b0, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Fflags_o !== 5'b00101) begin n_err++; $display("FAIL ovf_fflags got=%b exp=00101", bus.Fflags_o); end
      step(idle(), 1'b1, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Fflags_acc_o !== 5'b10101) begin n_err++; $display("FAIL ovf_acc got=%b exp=10101", bus.Fflags_acc_o); end
      step(idle(), 1'b1, 1'b0, 1'b1, 5'd0);
      n_cmp++; if (bus.Fflags_acc_o !== 5'd0) begin n_err++; $display("FAIL csr_clr got=%b exp=00000", bus.Fflags_acc_o); end
   endtask

   task automatic test_back_to_back();
      req_t        a, b, c;
      logic [15:0] cnt0;
      a = mk(1'b0, 8'h10, 23'h0000AA, 0, 0, 0, 0);
      b = mk(1'b1, 8'h20, 23'h0000BB, 0, 0, 0, 0);
      c = mk(1'b0, 8'h30, 23'h0000CC, 0, 0, 0, 0);
      cnt0 = bus.Retired_cnt_o;
      step(a, 1'b0, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready1 got=%b exp=1", bus.Ready_o); end
      step(b, 1'b0, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_full got=%b exp=0", bus.Ready_o); end
      step(c, 1'b0, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Result_o !== {a.s, a.e, a.m}) begin n_err++; $display("FAIL b2b_hold got=%h exp=%h", bus.Result_o, {a.s, a.e, a.m}); end
      n_cmp++; if (bus.Ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_still_full got=%b exp=0", bus.Ready_o); end
      step(c, 1'b1, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Result_o !== {b.s, b.e, b.m}) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", bus.Result_o, {b.s, b.e, b.m}); end
      n_cmp++; if (bus.Ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_reopen got=%b exp=1", bus.Ready_o); end
      step(c, 1'b1, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Result_o !== {c.s, c.e, c.m}) begin n_err++; $display("FAIL b2b_third got=%h exp=%h", bus.Result_o, {c.s, c.e, c.m}); end
      step(idle(), 1'b1, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_empty got=%b exp=0", bus.Valid_o); end
      n_cmp++; if (bus.Retired_cnt_o !== cnt0 + 16'd3) begin n_err++; $display("FAIL b2b_cnt got=%0d exp=%0d", bus.Retired_cnt_o, cnt0 + 16'd3); end
   endtask

   task automatic test_csr_merge();
      step(mk(1'b0, 8'h01, 23'd5, 0, 0, 0, 1), 1'b1, 1'b0, 1'b0, 5'd0);
      step(idle(), 1'b1, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Fflags_acc_o !== 5'b00001) begin n_err++; $display("FAIL csr_pre got=%b exp=00001", bus.Fflags_acc_o); end
      step(mk(1'b0, 8'h00, 23'd3, 0, 0, 1, 0), 1'b0, 1'b0, 1'b0, 5'd0);
      step(idle(), 1'b1, 1'b1, 1'b0, 5'b01000);
      n_cmp++; if (bus.Fflags_acc_o !== 5'b01010) begin n_err++; $display("FAIL csr_merge got=%b exp=01010", bus.Fflags_acc_o); end
      step(idle(), 1'b1, 1'b1, 1'b1, 5'b00100);
      n_cmp++; if (bus.Fflags_acc_o !== 5'b00100) begin n_err++; $display("FAIL csr_wr_prio got=%b exp=00100", bus.Fflags_acc_o); end
   endtask

   task automatic test_reset_mid();
      step(mk(1'b0, 8'h44, 23'd9, 0, 0, 0, 1), 1'b0, 1'b0, 1'b0, 5'd0);
      step(mk(1'b0, 8'h45, 23'd8, 0, 1, 0, 0), 1'b0, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_full got=%b exp=0", bus.Ready_o); end
      rst = 1'b1;
      step(mk(1'b1, 8'h46, 23'd7, 0, 0, 0, 0), 1'b1, 1'b1, 1'b0, 5'b11111);
      rst = 1'b0;
      n_cmp++; if (bus.Valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b exp=0", bus.Valid_o); end
      n_cmp++; if (bus.Ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", bus.Ready_o); end
      n_cmp++; if (bus.Result_o !== 32'd0) begin n_err++; $display("FAIL rstmid_result got=%h exp=0", bus.Result_o); end
      n_cmp++; if (bus.Fflags_o !== 5'd0) begin n_err++; $display("FAIL rstmid_fflags got=%b exp=0", bus.Fflags_o); end
      n_cmp++; if (bus.Fflags_acc_o !== 5'd0) begin n_err++; $display("FAIL rstmid_acc got=%b exp=0", bus.Fflags_acc_o); end
      n_cmp++; if (bus.Retired_cnt_o !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt got=%0d exp=0", bus.Retired_cnt_o); end
      step(mk(1'b0, 8'h80, 23'h400000, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 5'd0);
      n_cmp++; if (bus.Result_o !== 32'h4040_0000) begin n_err++; $display("FAIL rstmid_latency got=%h exp=40400000", bus.Result_o); end
      step(idle(), 1'b1, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic test_random();
      req_t r;
      logic rdy, wr, clr;
      logic [4:0] wd;
      for (int i = 0; i < 400; i++) begin
         r.v   = ($urandom_range(0, 3) != 0);
         r.s   = 1'($urandom);
         r.e   = 8'($urandom);
         r.m   = 23'($urandom);
         r.inv = ($urandom_range(0, 7) == 0);
         r.ovf = ($urandom_range(0, 7) == 0);
         r.unf = ($urandom_range(0, 7) == 0);
         r.inx = 1'($urandom);
         rdy   = ($urandom_range(0, 9) < 6);
         wr    = ($urandom_range(0, 15) == 0);
         clr   = ($urandom_range(0, 15) == 0);
         wd    = 5'($urandom);
         step(r, rdy, wr, clr, wd);
         n_cmp++;
         if (bus.Valid_o !== (mq.size() != 0) || bus.Ready_o !== (mq.size() != 2)) begin
            n_err++;
            $display("FAIL rand_hs cyc=%0d got v=%b r=%b exp depth=%0d", i, bus.Valid_o, bus.Ready_o, mq.size());
         end
         n_cmp++;
         if (mq.size() != 0) begin
            if (bus.Result_o !== mq[0].result || bus.Fflags_o !== mq[0].flags) begin
               n_err++;
               $display("FAIL rand_head cyc=%0d got %h/%b exp %h/%b", i, bus.Result_o, bus.Fflags_o, mq[0].result, mq[0].flags);
            end
         end else if (bus.Result_o !== 32'd0 || bus.Fflags_o !== 5'd0) begin
            n_err++;
            $display("FAIL rand_empty cyc=%0d got %h/%b exp 0/0", i, bus.Result_o, bus.Fflags_o);
         end
         n_cmp++;
         if (bus.Fflags_acc_o !== m_acc || bus.Retired_cnt_o !== m_cnt) begin
            n_err++;
            $display("FAIL rand_acc cyc=%0d got acc=%b cnt=%0d exp acc=%b cnt=%0d", i, bus.Fflags_acc_o, bus.Retired_cnt_o, m_acc, m_cnt);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      m_acc = 5'd0;
      m_cnt = 16'd0;
      rst   = 1'b1;
      test_reset();
      test_basic();
      test_invalid();
      test_overflow();
      test_back_to_back();
      test_csr_merge();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
